// File: rtl/shift_pkg.sv
// Shared constants for the 16-bit shift unit and its arbiter.
package shift_pkg;

  localparam int unsigned SH_W     = 16;
  localparam int unsigned SH_CNT_W = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  localparam logic ID_0 = 1'b0;
  localparam logic ID_1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter with a priority pointer; round-robin or fixed priority.
module rr_arb2 #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned PRIO_RESET = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  localparam logic PrioRst = (PRIO_RESET != 0);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (rst_n && en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end

    ptr_d = ptr_q;
    if (FIXED_PRIO != 0) begin
      ptr_d = PrioRst;
    end else if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= PrioRst;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shift16.sv
// Combinational 16-bit shifter: rotate/logical shift left/right by 0..15.
module shift16
  import shift_pkg::*;
(
  input  logic [SH_W-1:0]     din_i,
  input  logic [SH_CNT_W-1:0] cnt_i,
  input  logic [1:0]          op_i,
  output logic [SH_W-1:0]     dout_o
);

  logic [2*SH_W-1:0] rol_w;
  logic [2*SH_W-1:0] ror_w;

  // Rotates come from shifting a doubled copy of the operand.
  assign rol_w = {din_i, din_i} << cnt_i;
  assign ror_w = {din_i, din_i} >> cnt_i;

  always_comb begin
    dout_o = din_i;
    unique case (op_i)
      OP_ROL:  dout_o = rol_w[2*SH_W-1:SH_W];
      OP_SLL:  dout_o = din_i << cnt_i;
      OP_ROR:  dout_o = ror_w[SH_W-1:0];
      OP_SRL:  dout_o = din_i >> cnt_i;
      default: dout_o = din_i;
    endcase
  end

endmodule

// File: rtl/shift_arb.sv
// Arbitrates two shift requesters onto one shift16 and registers the tagged
// result behind a valid/ready handshake.
module shift_arb
  import shift_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned PRIO_RESET = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] in0,
  input  logic [3:0]  cnt0,
  input  logic [1:0]  op0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [15:0] in1,
  input  logic [3:0]  cnt1,
  input  logic [1:0]  op1,
  output logic        gnt1,
  output logic        res_valid,
  output logic        res_id,
  output logic [15:0] res_data,
  input  logic        res_ready
);

  logic            can_accept;
  logic [1:0]      gnt;
  logic [SH_W-1:0] sh_in, sh_out;
  logic [3:0]      sh_cnt;
  logic [1:0]      sh_op;

  logic            res_valid_q, res_valid_d;
  logic            res_id_q, res_id_d;
  logic [SH_W-1:0] res_data_q, res_data_d;

  // A slot frees up in the same cycle the consumer drains it.
  assign can_accept = !res_valid_q || res_ready;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO),
    .PRIO_RESET (PRIO_RESET)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({req1, req0}),
    .en_i  (can_accept),
    .gnt_o (gnt)
  );

  assign sh_in  = gnt[1] ? in1  : in0;
  assign sh_cnt = gnt[1] ? cnt1 : cnt0;
  assign sh_op  = gnt[1] ? op1  : op0;

  shift16 u_shift (
    .din_i  (sh_in),
    .cnt_i  (sh_cnt),
    .op_i   (sh_op),
    .dout_o (sh_out)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
    if (gnt != 2'b00) begin
      res_valid_d = 1'b1;
      res_id_d    = gnt[1] ? ID_1 : ID_0;
      res_data_d  = sh_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_id_q    <= ID_0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

  assign gnt0      = gnt[0];
  assign gnt1      = gnt[1];
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;

endmodule
